// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for front-panel select controllers: select width sizing
// and the lowest-set-bit priority encoder.
package mux_ctrl_pkg;

   localparam int unsigned SEL_NONE = 0;
   localparam int unsigned MAX_BTN  = 16;

   function automatic int unsigned sel_width(input int unsigned n_btn);
      return $clog2(n_btn + 1);
   endfunction

   // Index of the lowest set bit; returns 0 when no bit is set.
   function automatic logic [4:0] lowest_set(input logic [MAX_BTN-1:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int i = MAX_BTN - 1; i >= 0; i--) begin
         if (v[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw button.
// The stable output only follows the input after DEBOUNCE_CYCLES steady samples.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable
);

   logic sync1;
   logic bs;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         bs    <= 1'b0;
      end else begin
         sync1 <= raw;
         bs    <= sync1;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign stable = bs;
      end else begin : g_count
         localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

         logic [CW-1:0] cnt;
         logic          db;

         // cnt holds the number of consecutive samples that disagreed with db.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               cnt <= '0;
               db  <= 1'b0;
            end else if (bs == db) begin
               cnt <= '0;
            end else if (cnt == LAST) begin
               db  <= bs;
               cnt <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end

         assign stable = db;
      end
   endgenerate

endmodule

// File: rtl/mux_sel_ctrl.sv
// Front-panel mux select controller: debounced button presses set a sticky
// select code, the lock switch freezes it, and pressing all buttons clears it.
module mux_sel_ctrl
   import mux_ctrl_pkg::*;
#(
   parameter int unsigned N_BTN           = 5,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned SEL_W           = sel_width(N_BTN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] buttons,
   input  logic             lock,
   output logic [SEL_W-1:0] sel,
   output logic             changed
);

   logic [N_BTN-1:0]   db;
   logic [N_BTN-1:0]   db_q;
   logic [N_BTN-1:0]   press;
   logic [MAX_BTN-1:0] press_w;
   logic [SEL_W-1:0]   next_sel;
   logic               lock_s1;
   logic               ls;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .raw   (buttons[i]),
         .stable(db[i])
      );
   end

   assign press = db & ~db_q;

   always_comb begin
      press_w              = '0;
      press_w[N_BTN-1:0]   = press;
      if (&db) begin
         next_sel = SEL_W'(SEL_NONE);
      end else begin
         next_sel = SEL_W'(lowest_set(press_w)) + SEL_W'(1);
      end
   end

   // Presses seen while locked are dropped rather than held for later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lock_s1 <= 1'b0;
         ls      <= 1'b0;
         db_q    <= '0;
         sel     <= SEL_W'(SEL_NONE);
         changed <= 1'b0;
      end else begin
         lock_s1 <= lock;
         ls      <= lock_s1;
         db_q    <= db;
         changed <= 1'b0;
         if ((|press) && !ls) begin
            sel     <= next_sel;
            changed <= (next_sel != sel);
         end
      end
   end

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Randomised and directed checks of mux_sel_ctrl against a sample-history
// reference model; change events are matched through an expected queue.
module tb_mux_sel_ctrl;

   localparam int N   = 5;
   localparam int D   = 4;
   localparam int SW  = 3;
   localparam int N2  = 12;
   localparam int SW2 = 4;
   localparam int EW  = 32 + SW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  buttons = '0;
   logic          lock = 1'b0;
   logic [SW-1:0] sel;
   logic          changed;
   logic [N2-1:0] buttons2 = '0;
   logic          lock2 = 1'b0;
   logic [SW2-1:0] sel2;
   logic          changed2;

   int n_cmp = 0;
   int n_err = 0;
   int unsigned cyc = 0;
   logic [EW-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   mux_sel_ctrl #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .reset(reset), .buttons(buttons), .lock(lock),
      .sel(sel), .changed(changed)
   );

   mux_sel_ctrl #(.N_BTN(N2), .DEBOUNCE_CYCLES(0)) dut_p (
      .clk(clk), .reset(reset), .buttons(buttons2), .lock(lock2),
      .sel(sel2), .changed(changed2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [N-1:0]  m_s1, m_bs, m_db, m_db_q, m_press;
   logic          m_l1, m_ls, m_flip;
   logic [SW-1:0] m_sel, m_nsel;
   logic [N-1:0]  hist[$];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_s1 = '0; m_bs = '0; m_db = '0; m_db_q = '0;
         m_l1 = 1'b0; m_ls = 1'b0; m_sel = '0;
         hist.delete();
         exp_q.delete();
      end else begin
         cyc = cyc + 1;
         m_press = m_db & ~m_db_q;
         if (m_press != 0 && !m_ls) begin
            if (m_db == {N{1'b1}}) m_nsel = '0;
            else begin
               m_nsel = '0;
               for (int i = N - 1; i >= 0; i--) if (m_press[i]) m_nsel = SW'(i + 1);
            end
            if (m_nsel != m_sel) exp_q.push_back({cyc, m_nsel});
            m_sel = m_nsel;
         end
         m_db_q = m_db;
         // a button's stable level flips once the last D samples all disagree with it
         hist.push_back(m_bs);
         if (hist.size() > D) void'(hist.pop_front());
         if (hist.size() == D) begin
            for (int i = 0; i < N; i++) begin
               m_flip = 1'b1;
               foreach (hist[k]) if (hist[k][i] == m_db[i]) m_flip = 1'b0;
               if (m_flip) m_db[i] = ~m_db[i];
            end
         end
         m_bs = m_s1;
         m_s1 = buttons;
         m_ls = m_l1;
         m_l1 = lock;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [EW-1:0] mon_e;
   always @(negedge clk) begin
      check("sel_track", 32'(sel), 32'(m_sel));
      if (changed === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_changed", 32'(changed), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("chg_cycle", cyc, mon_e[EW-1:SW]);
            check("chg_sel", 32'(sel), 32'(mon_e[SW-1:0]));
         end
      end else if (exp_q.size() > 0 && exp_q[0][EW-1:SW] <= cyc) begin
         mon_e = exp_q.pop_front();
         check("missing_changed", 32'(changed), 32'd1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [N-1:0] v, input int n);
      @(negedge clk);
      buttons = v;
      repeat (n) @(posedge clk);
   endtask

   task automatic async_reset_check();
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("reset_sel", 32'(sel), 32'd0);
      check("reset_changed", 32'(changed), 32'd0);
      check("reset_sel2", 32'(sel2), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      check("init_sel", 32'(sel), 32'd0);
      check("init_changed", 32'(changed), 32'd0);
      reset = 1'b1;

      // single press latency
      @(negedge clk);
      buttons = 5'b00100;
      repeat (6) @(posedge clk);
      #1 check("press_e6_sel", 32'(sel), 32'd0);
      @(posedge clk);
      #1 check("press_e7_sel", 32'(sel), 32'd3);
      check("press_e7_changed", 32'(changed), 32'd1);
      @(posedge clk);
      #1 check("press_e8_changed", 32'(changed), 32'd0);
      drive('0, 12);
      check("release_keeps", 32'(sel), 32'd3);

      // glitch rejection, then a just-long-enough pulse
      drive(5'b00001, 3);
      drive('0, 12);
      check("glitch_sel", 32'(sel), 32'd3);
      drive(5'b00001, 4);
      drive('0, 12);
      check("pulse4_sel", 32'(sel), 32'd1);

      // simultaneous press, clear chord, re-press
      drive(5'b00100, 10);
      drive('0, 10);
      drive(5'b10111, 10);
      check("simul_sel", 32'(sel), 32'd1);
      drive(5'b11111, 10);
      check("chord_sel", 32'(sel), 32'd0);
      drive('0, 10);
      drive(5'b00010, 10);
      drive('0, 10);
      drive(5'b00010, 10);
      check("repress_sel", 32'(sel), 32'd2);
      drive('0, 10);

      // lock drops presses and does not replay them
      @(negedge clk);
      lock = 1'b1;
      drive('0, 3);
      drive(5'b10000, 10);
      check("locked_sel", 32'(sel), 32'd2);
      drive('0, 10);
      @(negedge clk);
      lock = 1'b0;
      drive('0, 10);
      check("unlock_sel", 32'(sel), 32'd2);
      drive(5'b10000, 10);
      check("unlock_press_sel", 32'(sel), 32'd5);

      async_reset_check();

      // randomised phase
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) lock = ~lock;
         if (i == 150) async_reset_check();
         if ($urandom_range(0, 1) == 0) drive(N'(1 << $urandom_range(0, N - 1)), $urandom_range(1, 8));
         else drive(N'($urandom_range(0, 31)), $urandom_range(1, 8));
      end
      lock = 1'b0;
      drive('0, 20);

      // bypass-debounce instance, 12 buttons
      @(negedge clk);
      buttons2 = 12'h800;
      repeat (2) @(posedge clk);
      #1 check("param_e2_sel", 32'(sel2), 32'd0);
      @(posedge clk);
      #1 check("param_e3_sel", 32'(sel2), 32'd12);
      check("param_e3_changed", 32'(changed2), 32'd1);
      @(posedge clk);
      #1 check("param_e4_changed", 32'(changed2), 32'd0);

      repeat (4) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
